// File: rtl/debounce_sync.sv
// Input conditioner: synchronises a bouncy asynchronous level into the clk domain,
// qualifies each change over a stability window and emits registered rise/fall pulses.
module debounce_sync #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a_raw,
    output logic c,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        STABLE_LO = 2'b00,
        CHECK_HI  = 2'b01,
        STABLE_HI = 2'b11,
        CHECK_LO  = 2'b10
    } state_t;

    logic [SYNC_STAGES-1:0] sync;
    logic                   a_sync;
    state_t                 state;
    state_t                 state_next;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_next;
    logic                   rise_next;
    logic                   fall_next;
    logic                   c_next;
    logic                   busy_next;

    // Plain flop chain; nothing sits between stages so metastability can settle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], a_raw};
        end
    end

    assign a_sync = sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= STABLE_LO;
            cnt   <= '0;
            c     <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            c     <= c_next;
            rise  <= rise_next;
            fall  <= fall_next;
            busy  <= busy_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        rise_next  = 1'b0;
        fall_next  = 1'b0;
        case (state)
            STABLE_LO: begin
                if (a_sync) begin
                    state_next = CHECK_HI;
                    cnt_next   = '0;
                end
            end
            CHECK_HI: begin
                if (!a_sync) begin
                    state_next = STABLE_LO;
                end else if (cnt == CNT_MAX) begin
                    state_next = STABLE_HI;
                    rise_next  = 1'b1;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            STABLE_HI: begin
                if (!a_sync) begin
                    state_next = CHECK_LO;
                    cnt_next   = '0;
                end
            end
            CHECK_LO: begin
                if (a_sync) begin
                    state_next = STABLE_HI;
                end else if (cnt == CNT_MAX) begin
                    state_next = STABLE_LO;
                    fall_next  = 1'b1;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: begin
                state_next = STABLE_LO;
                cnt_next   = '0;
            end
        endcase
        // c and busy are registered copies of what the next state implies.
        c_next    = (state_next == STABLE_HI) || (state_next == CHECK_LO);
        busy_next = (state_next == CHECK_HI) || (state_next == CHECK_LO);
    end

endmodule

// File: tb/tb_debounce_sync.sv
// Self-checking bench: table of per-edge vectors for the default build plus
// hand-written sequences for a SYNC_STAGES=3 / DEBOUNCE_CYCLES=1 build.
module tb_debounce_sync;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic a_raw = 1'b0;
    logic c, rise, fall, busy;
    logic rst_n2 = 1'b0;
    logic a_raw2 = 1'b0;
    logic c2, rise2, fall2, busy2;

    int tests = 0;
    int errors = 0;

    always #5 clk = ~clk;

    debounce_sync dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a_raw (a_raw),
        .c     (c),
        .rise  (rise),
        .fall  (fall),
        .busy  (busy)
    );

    debounce_sync #(.SYNC_STAGES(3), .DEBOUNCE_CYCLES(1)) dut2 (
        .clk   (clk),
        .rst_n (rst_n2),
        .a_raw (a_raw2),
        .c     (c2),
        .rise  (rise2),
        .fall  (fall2),
        .busy  (busy2)
    );

    // Expected outputs packed as {c, rise, fall, busy}
    localparam logic [3:0] O  = 4'b0000;
    localparam logic [3:0] B  = 4'b0001;
    localparam logic [3:0] CR = 4'b1100;
    localparam logic [3:0] C  = 4'b1000;
    localparam logic [3:0] CB = 4'b1001;
    localparam logic [3:0] F  = 4'b0010;

    typedef struct {
        logic       rst_n;
        logic       a_raw;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic void addVec(input logic r, input logic a, input logic [3:0] e);
        vec_t v;
        v.rst_n = r;
        v.a_raw = a;
        v.exp   = e;
        vecs.push_back(v);
    endfunction

    function automatic void addRun(input logic a, input logic [3:0] e0, input logic [3:0] e1,
                                   input logic [3:0] e2, input logic [3:0] e3,
                                   input logic [3:0] e4, input logic [3:0] e5,
                                   input logic [3:0] e6, input logic [3:0] e7);
        addVec(1'b1, a, e0); addVec(1'b1, a, e1); addVec(1'b1, a, e2); addVec(1'b1, a, e3);
        addVec(1'b1, a, e4); addVec(1'b1, a, e5); addVec(1'b1, a, e6); addVec(1'b1, a, e7);
    endfunction

    task automatic applyStimulus(input logic r, input logic a, input bit second,
                                 output logic [3:0] act);
        @(negedge clk);
        if (second) begin
            rst_n2 = r;
            a_raw2 = a;
        end else begin
            rst_n = r;
            a_raw = a;
        end
        @(posedge clk);
        #1;
        act = second ? {c2, rise2, fall2, busy2} : {c, rise, fall, busy};
    endtask

    task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: {c,rise,fall,busy} got %b expected %b", name, act, exp);
        end
    endtask

    initial begin
        logic [3:0] act;
        logic       seq_a[8];
        logic [3:0] seq_e[8];

        // Reset held with a_raw high, then release and let it qualify high
        addVec(1'b0, 1'b1, O); addVec(1'b0, 1'b1, O); addVec(1'b0, 1'b1, O);
        addRun(1'b1, O, O, B, B, B, B, CR, C);
        // Clean fall, clean rise, clean fall
        addRun(1'b0, C, C, CB, CB, CB, CB, F, O);
        addRun(1'b1, O, O, B, B, B, B, CR, C);
        addRun(1'b0, C, C, CB, CB, CB, CB, F, O);
        // 4-cycle glitch rejected
        addVec(1'b1, 1'b1, O); addVec(1'b1, 1'b1, O); addVec(1'b1, 1'b1, B); addVec(1'b1, 1'b1, B);
        addVec(1'b1, 1'b0, B); addVec(1'b1, 1'b0, B); addVec(1'b1, 1'b0, O); addVec(1'b1, 1'b0, O);
        // 5-cycle pulse accepted, then falls back
        addVec(1'b1, 1'b1, O); addVec(1'b1, 1'b1, O); addVec(1'b1, 1'b1, B); addVec(1'b1, 1'b1, B);
        addVec(1'b1, 1'b1, B);
        addRun(1'b0, B, CR, CB, CB, CB, CB, F, O);
        // Bounce train 1,0,1,1,0,1 then held high
        addVec(1'b1, 1'b1, O); addVec(1'b1, 1'b0, O); addVec(1'b1, 1'b1, B); addVec(1'b1, 1'b1, O);
        addVec(1'b1, 1'b0, B); addVec(1'b1, 1'b1, B);
        addVec(1'b1, 1'b1, O); addVec(1'b1, 1'b1, B); addVec(1'b1, 1'b1, B); addVec(1'b1, 1'b1, B);
        addVec(1'b1, 1'b1, B); addVec(1'b1, 1'b1, CR); addVec(1'b1, 1'b1, C);
        addRun(1'b0, C, C, CB, CB, CB, CB, F, O);
        // Reset during CHECK_HI aborts qualification; latency restarts after release
        addVec(1'b1, 1'b1, O); addVec(1'b1, 1'b1, O); addVec(1'b1, 1'b1, B); addVec(1'b1, 1'b1, B);
        addVec(1'b0, 1'b1, O);
        addRun(1'b1, O, O, B, B, B, B, CR, C);
        // Long constant hold: no spurious activity
        for (int i = 0; i < 20; i++) addVec(1'b1, 1'b1, C);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst_n, vecs[i].a_raw, 1'b0, act);
            checkOutput($sformatf("vec%0d", i), act, vecs[i].exp);
        end

        // Second build: reset, then a 2-cycle pulse must be accepted
        applyStimulus(1'b0, 1'b1, 1'b1, act);
        checkOutput("p2_reset0", act, O);
        applyStimulus(1'b0, 1'b0, 1'b1, act);
        checkOutput("p2_reset1", act, O);
        seq_a = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        seq_e = '{O, O, O, B, CR, CB, F, O};
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, seq_a[i], 1'b1, act);
            checkOutput($sformatf("p2_pulse2_e%0d", i + 1), act, seq_e[i]);
        end
        // A 1-cycle pulse must be rejected
        seq_a = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        seq_e = '{O, O, O, B, O, O, O, O};
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, seq_a[i], 1'b1, act);
            checkOutput($sformatf("p2_pulse1_e%0d", i + 1), act, seq_e[i]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/debounce_sync.md
Name: debounce_sync

Overview:
- Input-conditioning stage directly upstream of the single-bit buffer. It cleans an asynchronous, bouncy raw input before it drives the buffer's `a` input.
- Synchronises the raw signal into the clk domain, rejects glitches shorter than a programmable window, and presents a clean level `c`.
- Also emits single-cycle rise/fall event pulses for downstream logic.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops; legal range >= 2.
- DEBOUNCE_CYCLES, 4, extra consecutive stable samples required after the first differing sample; legal range >= 1.
- CNT_W (localparam), derived as clog2(DEBOUNCE_CYCLES)+1, width of the stability counter.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- a_raw  input  1  asynchronous, possibly bouncing raw input.
- c  output  1  debounced, synchronised level; feeds buffer input `a`.
- rise  output  1  one-cycle pulse, coincident with the cycle c goes 0->1.
- fall  output  1  one-cycle pulse, coincident with the cycle c goes 1->0.
- busy  output  1  high while in a CHECK state (transition under qualification).

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - synchroniser flops <= 0, state <= STABLE_LO, cnt <= 0.
  - c=0, rise=0, fall=0, busy=0.
  - Reset wins over all other activity, including a mid-CHECK qualification. That qualification is aborted with no pulse.
- Synchroniser:
  - s[0] <= a_raw, s[i] <= s[i-1].
  - a_sync = s[SYNC_STAGES-1].
  - No logic is placed between synchroniser flops.
- FSM states and transitions:
  - STABLE_LO (c=0): if a_sync=1 -> CHECK_HI, cnt<=0; else stay.
  - CHECK_HI (c=0, busy=1): if a_sync=0 -> STABLE_LO (glitch rejected, no pulse). Else if cnt==DEBOUNCE_CYCLES-1 -> STABLE_HI, c<=1, rise<=1. Else cnt<=cnt+1.
  - STABLE_HI (c=1): if a_sync=0 -> CHECK_LO, cnt<=0; else stay.
  - CHECK_LO (c=1, busy=1): if a_sync=1 -> STABLE_HI (glitch rejected). Else if cnt==DEBOUNCE_CYCLES-1 -> STABLE_LO, c<=0, fall<=1. Else cnt<=cnt+1.
- Outputs: c, rise, fall and busy are all registered. rise and fall are high for exactly one cycle and are never high together.
- Acceptance rule: a_sync must hold the new value for DEBOUNCE_CYCLES+1 consecutive sampling edges.
- Latency:
  - a_raw is stable before edge 1.
  - c changes after edge SYNC_STAGES+DEBOUNCE_CYCLES+1; with defaults, that is edge 7.
  - The rise/fall pulse is asserted in the same cycle that c changes.
- Glitch width: any a_raw pulse of at most DEBOUNCE_CYCLES clk periods (synchronous sampling) leaves c unchanged. A pulse of DEBOUNCE_CYCLES+1 periods is accepted.
- Counter:
  - cnt never exceeds DEBOUNCE_CYCLES-1 and does not wrap.
  - cnt is cleared on every entry to a CHECK state, so a re-bounce restarts qualification from zero.
- A bounce back inside CHECK returns to the originating STABLE state in one cycle. A new transition can start on the next differing sample.
- With a_raw held constant, state stays STABLE_* indefinitely; no spurious pulses.
- Illegal state encodings recover to STABLE_LO on the next edge, with c=0.

Test Plan:
1. Reset: hold rst_n=0 for 3 cycles with a_raw=1 -> c=0, rise=0, fall=0, busy=0 throughout. After release, with a_raw=1: c=1 at edge 7 after release, and rise=1 for that single cycle only.
2. Clean rise/fall (defaults): a_raw 0->1 synchronous to edge 0 -> busy=1 from edge 3, c=1 and rise=1 after edge 7, rise=0 after edge 8. Then a_raw 1->0 -> c=0 and fall=1 seven edges later.
3. Glitch boundary: with c=0, a_raw high for 4 cycles then low -> c stays 0, rise never asserts, busy returns to 0. Repeat with a 5-cycle pulse -> c=1, rise pulses once.
4. Bounce train: a_raw toggles 1,0,1,1,0,1 (one value per cycle), then held 1 -> c stays 0 during the toggling. c=1 exactly 7 edges after the final 0->1 transition; exactly one rise pulse.
5. Reset mid-qualification: a_raw 0->1, assert rst_n=0 at edge 5 (in CHECK_HI) -> c=0, busy=0, no rise after that edge. Release with a_raw still 1 -> full 7-edge latency restarts.
6. Parameter sweep: SYNC_STAGES=3, DEBOUNCE_CYCLES=1 -> accept a 2-cycle pulse with c changing after edge 5; reject a 1-cycle pulse.
